// File: rtl/front_sprite_ctrl.sv
// Front-sprite animation sequencer: enter / hit / faint / hide commands driving position, sheet select and visibility.
// Optional idle bob in SHOWN is enabled with FRONT_CTRL_IDLE_BOB_EN.
module front_sprite_ctrl #(
    parameter int unsigned X_START      = 640,
    parameter int unsigned X_HOME       = 400,
    parameter int unsigned Y_HOME       = 60,
    parameter int unsigned STEP         = 8,
    parameter int unsigned BLINK_FRAMES = 4,
    parameter int unsigned HIT_BLINKS   = 6,
    parameter int unsigned FAINT_DIST   = 56
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        cmd_valid_in,
    input  logic [1:0]  cmd_in,
    input  logic [4:0]  species_in,
    output logic        cmd_ready_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [9:0]  sprite_sel_x_out,
    output logic [8:0]  sprite_sel_y_out,
    output logic        visible_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out
);

    localparam int unsigned XW         = 11;
    localparam int unsigned YW         = 10;
    localparam int unsigned SXW        = 10;
    localparam int unsigned SYW        = 9;
    localparam int unsigned SPW        = 5;
    localparam int unsigned FCW        = 8;
    localparam int unsigned BCW        = 8;
    localparam int unsigned ACW        = 12;
    localparam int unsigned N_SPECIES  = 28;
    localparam int unsigned SHEET_COLS = 14;
    localparam int unsigned CELL       = 56;

    localparam logic [1:0] CMD_ENTER = 2'd0;
    localparam logic [1:0] CMD_HIT   = 2'd1;
    localparam logic [1:0] CMD_FAINT = 2'd2;
    localparam logic [1:0] CMD_HIDE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER,
        ST_SHOWN,
        ST_HIT,
        ST_FAINT
    } state_e;

    state_e          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [SXW-1:0]  sel_x_q;
    logic [SYW-1:0]  sel_y_q;
    logic            vis_q;
    logic            done_q;
    logic            err_q;
    logic [FCW-1:0]  frame_cnt_q;
    logic [BCW-1:0]  blink_cnt_q;
    logic [ACW-1:0]  acc_q;
`ifdef FRONT_CTRL_IDLE_BOB_EN
    logic [3:0]      bob_cnt_q;
    logic            bob_phase_q;
`endif

    // One bit wider than the outputs so a step can never silently wrap.
    logic [XW:0]     x_dec_d;
    logic [YW:0]     y_inc_d;
    logic [ACW-1:0]  acc_inc_d;
    logic [SXW-1:0]  sel_x_d;
    logic [SYW-1:0]  sel_y_d;
    logic            enter_ok_d;

    always_comb begin
        x_dec_d    = {1'b0, x_q} - (XW+1)'(STEP);
        y_inc_d    = {1'b0, y_q} + (YW+1)'(STEP);
        acc_inc_d  = acc_q + ACW'(STEP);
        sel_x_d    = SXW'((32'(species_in) % SHEET_COLS) * CELL);
        sel_y_d    = SYW'((32'(species_in) / SHEET_COLS) * CELL);
        enter_ok_d = (state_q == ST_IDLE) && (species_in < SPW'(N_SPECIES));
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            x_q         <= XW'(X_START);
            y_q         <= YW'(Y_HOME);
            sel_x_q     <= '0;
            sel_y_q     <= '0;
            vis_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            acc_q       <= '0;
`ifdef FRONT_CTRL_IDLE_BOB_EN
            bob_cnt_q   <= '0;
            bob_phase_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // A command in the same cycle as a tick swallows that tick.
            if (cmd_valid_in) begin
                if (cmd_in == CMD_HIDE) begin
                    state_q     <= ST_IDLE;
                    vis_q       <= 1'b0;
                    x_q         <= XW'(X_START);
                    y_q         <= YW'(Y_HOME);
                    frame_cnt_q <= '0;
                    blink_cnt_q <= '0;
                    acc_q       <= '0;
                end else if (cmd_in == CMD_ENTER && enter_ok_d) begin
                    state_q <= ST_ENTER;
                    vis_q   <= 1'b1;
                    x_q     <= XW'(X_START);
                    y_q     <= YW'(Y_HOME);
                    sel_x_q <= sel_x_d;
                    sel_y_q <= sel_y_d;
                end else if (cmd_in == CMD_HIT && state_q == ST_SHOWN) begin
                    state_q     <= ST_HIT;
                    vis_q       <= 1'b1;
                    y_q         <= YW'(Y_HOME);
                    frame_cnt_q <= '0;
                    blink_cnt_q <= '0;
                end else if (cmd_in == CMD_FAINT && state_q == ST_SHOWN) begin
                    state_q <= ST_FAINT;
                    y_q     <= YW'(Y_HOME);
                    acc_q   <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (frame_tick_in) begin
                case (state_q)
                    ST_ENTER: begin
                        if (x_dec_d[XW] || x_dec_d <= (XW+1)'(X_HOME)) begin
                            x_q     <= XW'(X_HOME);
                            state_q <= ST_SHOWN;
                            done_q  <= 1'b1;
`ifdef FRONT_CTRL_IDLE_BOB_EN
                            bob_cnt_q   <= '0;
                            bob_phase_q <= 1'b0;
`endif
                        end else begin
                            x_q <= x_dec_d[XW-1:0];
                        end
                    end
                    ST_SHOWN: begin
`ifdef FRONT_CTRL_IDLE_BOB_EN
                        bob_cnt_q <= bob_cnt_q + 4'd1;
                        if (bob_cnt_q == 4'd15) begin
                            bob_phase_q <= ~bob_phase_q;
                            y_q         <= bob_phase_q ? YW'(Y_HOME) : YW'(Y_HOME + 2);
                        end
`endif
                    end
                    ST_HIT: begin
                        if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                            frame_cnt_q <= '0;
                            if (blink_cnt_q == BCW'(HIT_BLINKS - 1)) begin
                                vis_q       <= 1'b1;
                                blink_cnt_q <= '0;
                                state_q     <= ST_SHOWN;
                                done_q      <= 1'b1;
`ifdef FRONT_CTRL_IDLE_BOB_EN
                                bob_cnt_q   <= '0;
                                bob_phase_q <= 1'b0;
`endif
                            end else begin
                                vis_q       <= ~vis_q;
                                blink_cnt_q <= blink_cnt_q + BCW'(1);
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FCW'(1);
                        end
                    end
                    ST_FAINT: begin
                        if (acc_inc_d >= ACW'(FAINT_DIST)) begin
                            state_q <= ST_IDLE;
                            vis_q   <= 1'b0;
                            x_q     <= XW'(X_START);
                            y_q     <= YW'(Y_HOME);
                            acc_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            acc_q <= acc_inc_d;
                            y_q   <= y_inc_d[YW] ? '1 : y_inc_d[YW-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready_out    = (state_q == ST_IDLE) || (state_q == ST_SHOWN);
    assign busy_out         = (state_q == ST_ENTER) || (state_q == ST_HIT) || (state_q == ST_FAINT);
    assign x_out            = x_q;
    assign y_out            = y_q;
    assign sprite_sel_x_out = sel_x_q;
    assign sprite_sel_y_out = sel_y_q;
    assign visible_out      = vis_q;
    assign done_out         = done_q;
    assign err_out          = err_q;

endmodule

// File: tb/tb_front_sprite_ctrl.sv
// Bench for front_sprite_ctrl: directed sequence with randomized species and tick spacing,
// expectations computed arithmetically from the animation rules.
module tb_front_sprite_ctrl;

    localparam int X_START      = 640;
    localparam int X_HOME       = 400;
    localparam int Y_HOME       = 60;
    localparam int STEP         = 8;
    localparam int BLINK_FRAMES = 4;
    localparam int HIT_BLINKS   = 6;
    localparam int FAINT_DIST   = 56;

    localparam int ENTER_TICKS = (X_START - X_HOME + STEP - 1) / STEP;
    localparam int HIT_TICKS   = HIT_BLINKS * BLINK_FRAMES;
    localparam int FAINT_TICKS = (FAINT_DIST + STEP - 1) / STEP;

    localparam logic [1:0] C_ENTER = 2'd0;
    localparam logic [1:0] C_HIT   = 2'd1;
    localparam logic [1:0] C_FAINT = 2'd2;
    localparam logic [1:0] C_HIDE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_tick_in = 1'b0;
    logic        cmd_valid_in = 1'b0;
    logic [1:0]  cmd_in = 2'd0;
    logic [4:0]  species_in = 5'd0;
    logic        cmd_ready_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [9:0]  sprite_sel_x_out;
    logic [8:0]  sprite_sel_y_out;
    logic        visible_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    int tests = 0;
    int fails = 0;

    front_sprite_ctrl #(
        .X_START(X_START), .X_HOME(X_HOME), .Y_HOME(Y_HOME), .STEP(STEP),
        .BLINK_FRAMES(BLINK_FRAMES), .HIT_BLINKS(HIT_BLINKS), .FAINT_DIST(FAINT_DIST)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in(rst_in),
        .frame_tick_in(frame_tick_in),
        .cmd_valid_in(cmd_valid_in),
        .cmd_in(cmd_in),
        .species_in(species_in),
        .cmd_ready_out(cmd_ready_out),
        .x_out(x_out),
        .y_out(y_out),
        .sprite_sel_x_out(sprite_sel_x_out),
        .sprite_sel_y_out(sprite_sel_y_out),
        .visible_out(visible_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, release strobes #1 later.
    task automatic drive(input logic tick, input logic v, input logic [1:0] c, input logic [4:0] s);
        frame_tick_in = tick;
        cmd_valid_in  = v;
        cmd_in        = c;
        species_in    = s;
        @(posedge clk);
        #1;
        frame_tick_in = 1'b0;
        cmd_valid_in  = 1'b0;
    endtask

    task automatic tick_gap();
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0, 1'b0, C_ENTER, 5'd0);
            chk("gap_done", 32'(done_out), 32'd0);
        end
        drive(1'b1, 1'b0, C_ENTER, 5'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x"}, 32'(x_out), 32'(X_START));
        chk({tag, "_y"}, 32'(y_out), 32'(Y_HOME));
        chk({tag, "_vis"}, 32'(visible_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready_out), 32'd1);
        chk({tag, "_done"}, 32'(done_out), 32'd0);
        chk({tag, "_err"}, 32'(err_out), 32'd0);
    endtask

    function automatic int enter_x(input int k);
        int x;
        x = X_START - k * STEP;
        return (x > X_HOME) ? x : X_HOME;
    endfunction

    task automatic run_enter(input logic [4:0] sp);
        drive(1'b0, 1'b1, C_ENTER, sp);
        chk("enter_selx", 32'(sprite_sel_x_out), 32'((int'(sp) % 14) * 56));
        chk("enter_sely", 32'(sprite_sel_y_out), 32'((int'(sp) / 14) * 56));
        chk("enter_x0", 32'(x_out), 32'(X_START));
        chk("enter_vis", 32'(visible_out), 32'd1);
        chk("enter_busy", 32'(busy_out), 32'd1);
        for (int k = 1; k <= ENTER_TICKS; k++) begin
            tick_gap();
            chk("enter_x", 32'(x_out), 32'(enter_x(k)));
            chk("enter_done", 32'(done_out), 32'(k == ENTER_TICKS));
            chk("enter_busy_k", 32'(busy_out), 32'(k < ENTER_TICKS));
        end
        drive(1'b0, 1'b0, C_ENTER, 5'd0);
        chk("shown_done_clr", 32'(done_out), 32'd0);
        chk("shown_ready", 32'(cmd_ready_out), 32'd1);
        chk("shown_y", 32'(y_out), 32'(Y_HOME));
    endtask

    initial begin
        logic [4:0] sp;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk_idle("reset");
        chk("reset_selx", 32'(sprite_sel_x_out), 32'd0);
        chk("reset_sely", 32'(sprite_sel_y_out), 32'd0);

        // Illegal commands from IDLE
        drive(1'b0, 1'b1, C_HIT, 5'd0);
        chk("hit_idle_err", 32'(err_out), 32'd1);
        chk("hit_idle_done", 32'(done_out), 32'd0);
        chk("hit_idle_ready", 32'(cmd_ready_out), 32'd1);
        chk("hit_idle_vis", 32'(visible_out), 32'd0);
        drive(1'b0, 1'b0, C_ENTER, 5'd0);
        chk("err_clear", 32'(err_out), 32'd0);
        drive(1'b0, 1'b1, C_ENTER, 5'd28);
        chk("sp28_err", 32'(err_out), 32'd1);
        chk("sp28_busy", 32'(busy_out), 32'd0);
        chk("sp28_selx", 32'(sprite_sel_x_out), 32'd0);
        drive(1'b0, 1'b1, C_FAINT, 5'd0);
        chk("faint_idle_err", 32'(err_out), 32'd1);
        chk("faint_idle_vis", 32'(visible_out), 32'd0);

        // ENTER species 17, plus a rejected second ENTER mid-animation
        drive(1'b0, 1'b1, C_ENTER, 5'd17);
        chk("sp17_selx", 32'(sprite_sel_x_out), 32'd168);
        chk("sp17_sely", 32'(sprite_sel_y_out), 32'd56);
        chk("sp17_err", 32'(err_out), 32'd0);
        drive(1'b0, 1'b1, C_ENTER, 5'd3);
        chk("reenter_err", 32'(err_out), 32'd1);
        chk("reenter_x", 32'(x_out), 32'(X_START));
        chk("reenter_selx", 32'(sprite_sel_x_out), 32'd168);
        chk("reenter_busy", 32'(busy_out), 32'd1);
        for (int k = 1; k <= ENTER_TICKS; k++) begin
            tick_gap();
            chk("sp17_x", 32'(x_out), 32'(enter_x(k)));
            chk("sp17_done", 32'(done_out), 32'(k == ENTER_TICKS));
        end
        drive(1'b0, 1'b0, C_ENTER, 5'd0);
        chk("sp17_shown_ready", 32'(cmd_ready_out), 32'd1);
        chk("sp17_shown_busy", 32'(busy_out), 32'd0);

        // HIT blink sequence
        drive(1'b0, 1'b1, C_HIT, 5'd0);
        chk("hit_busy", 32'(busy_out), 32'd1);
        chk("hit_vis0", 32'(visible_out), 32'd1);
        for (int k = 1; k <= HIT_TICKS; k++) begin
            tick_gap();
            chk("hit_vis", 32'(visible_out), 32'(((k / BLINK_FRAMES) % 2) == 0));
            chk("hit_done", 32'(done_out), 32'(k == HIT_TICKS));
        end
        drive(1'b0, 1'b0, C_ENTER, 5'd0);
        chk("hit_end_busy", 32'(busy_out), 32'd0);
        chk("hit_end_x", 32'(x_out), 32'(X_HOME));

        // FAINT drop
        drive(1'b0, 1'b1, C_FAINT, 5'd0);
        chk("faint_busy", 32'(busy_out), 32'd1);
        for (int k = 1; k <= FAINT_TICKS; k++) begin
            tick_gap();
            if (k < FAINT_TICKS) begin
                chk("faint_y", 32'(y_out), 32'(Y_HOME + k * STEP));
                chk("faint_vis", 32'(visible_out), 32'd1);
            end else begin
                chk("faint_end_y", 32'(y_out), 32'(Y_HOME));
                chk("faint_end_vis", 32'(visible_out), 32'd0);
                chk("faint_end_x", 32'(x_out), 32'(X_START));
                chk("faint_end_ready", 32'(cmd_ready_out), 32'd1);
            end
            chk("faint_done", 32'(done_out), 32'(k == FAINT_TICKS));
        end

        // Random species, full entries followed by HIDE from SHOWN
        for (int r = 0; r < 3; r++) begin
            sp = 5'($urandom_range(0, 27));
            run_enter(sp);
            drive(1'b0, 1'b1, C_HIDE, 5'd0);
            chk_idle("hide_shown");
        end

        // ENTER accepted together with a tick: tick is ignored
        sp = 5'($urandom_range(0, 27));
        drive(1'b1, 1'b1, C_ENTER, sp);
        chk("enter_tick_x", 32'(x_out), 32'(X_START));
        chk("enter_tick_busy", 32'(busy_out), 32'd1);
        n = $urandom_range(1, ENTER_TICKS - 1);
        for (int k = 1; k <= n; k++) begin
            tick_gap();
            chk("pre_hide_x", 32'(x_out), 32'(enter_x(k)));
        end
        // HIDE with a simultaneous tick mid-ENTER
        drive(1'b1, 1'b1, C_HIDE, 5'd0);
        chk_idle("hide_tick");
        drive(1'b1, 1'b0, C_ENTER, 5'd0);
        chk("hide_idle_tick_x", 32'(x_out), 32'(X_START));
        chk("hide_idle_tick_done", 32'(done_out), 32'd0);

        // Asynchronous reset in the middle of FAINT
        run_enter(5'd27);
        drive(1'b0, 1'b1, C_FAINT, 5'd0);
        for (int k = 1; k <= 3; k++) tick_gap();
        chk("pre_rst_y", 32'(y_out), 32'(Y_HOME + 3 * STEP));
        #3;
        rst_in = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_selx", 32'(sprite_sel_x_out), 32'd0);
        chk("async_rst_sely", 32'(sprite_sel_y_out), 32'd0);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk_idle("post_rst");
        run_enter(5'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
